// File: rtl/sd_sector_responder.sv
// Moves one 512-byte sector per sd_rd/sd_wr request between the host stream channels and the buffer RAM.
// Defining SD_RESP_TIMEOUT_EN adds a per-request watchdog that aborts a stalled request and sets err.
module sd_sector_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [7:0]  sd_buff_addr,
    output logic [15:0] sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [15:0] sd_buff_din,
    output logic        host_cmd_valid,
    input  logic        host_cmd_ready,
    output logic        host_cmd_write,
    output logic [31:0] host_cmd_lba,
    input  logic [15:0] host_rdata,
    input  logic        host_rdata_valid,
    output logic        host_rdata_ready,
    output logic [15:0] host_wdata,
    output logic        host_wdata_valid,
    input  logic        host_wdata_ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, REQ, RD_XFER, RD_LAST, WR_XFER, DONE} state_t;
    state_t r_state, w_next;

    logic [8:0]  r_cnt;
    logic [8:0]  r_fetch_cnt;
    logic [7:0]  r_buff_addr;
    logic [15:0] r_buff_dout;
    logic        r_buff_wr;
    logic [31:0] r_cmd_lba;
    logic        r_cmd_write;
    logic [15:0] r_fifo [2];
    logic        r_wptr;
    logic        r_rptr;
    logic        r_inflight;
    logic [1:0]  r_occ;

    logic        w_accept;
    logic        w_cmd_valid;
    logic        w_rdata_ready;
    logic        w_wdata_valid;
    logic        w_cmd_hs;
    logic        w_rd_hs;
    logic        w_wr_hs;
    logic        w_fetch;
    logic        w_timeout;
    logic [2:0]  w_level;

    assign w_accept      = (r_state == IDLE) && (sd_rd || sd_wr);
    assign w_cmd_valid   = (r_state == REQ) && !w_timeout;
    assign w_rdata_ready = (r_state == RD_XFER) && !w_timeout;
    assign w_wdata_valid = (r_state == WR_XFER) && (r_occ != 2'd0) && !w_timeout;
    assign w_cmd_hs      = w_cmd_valid && host_cmd_ready;
    assign w_rd_hs       = w_rdata_ready && host_rdata_valid;
    assign w_wr_hs       = w_wdata_valid && host_wdata_ready;

    // Count the word leaving this cycle as already gone so the prefetch keeps pace at one word per cycle.
    assign w_level = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_wr_hs};
    assign w_fetch = (r_state == WR_XFER) && !w_timeout && !r_fetch_cnt[8] && (w_level < 3'd2);

`ifdef SD_RESP_TIMEOUT_EN
    logic [23:0] r_to_cnt;
    logic        r_err;
    logic        w_to_active;

    assign w_to_active = (r_state == REQ) || (r_state == RD_XFER) || (r_state == WR_XFER);
    assign w_timeout   = w_to_active && (r_to_cnt == 24'd0);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_to_cnt <= 24'd0;
            r_err    <= 1'b0;
        end else begin
            if (!w_to_active || w_cmd_hs || w_rd_hs || w_wr_hs)
                r_to_cnt <= TIMEOUT_CYCLES - 24'd1;
            else if (r_to_cnt != 24'd0)
                r_to_cnt <= r_to_cnt - 24'd1;
            if (w_accept)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sd_rd || sd_wr) w_next = REQ;
            REQ: begin
                if (w_timeout)
                    w_next = DONE;
                else if (w_cmd_hs)
                    w_next = r_cmd_write ? WR_XFER : RD_XFER;
            end
            RD_XFER: begin
                if (w_timeout)
                    w_next = DONE;
                else if (w_rd_hs && (r_cnt == 9'd255))
                    w_next = RD_LAST;
            end
            RD_LAST: w_next = DONE;
            WR_XFER: begin
                if (w_timeout)
                    w_next = DONE;
                else if (w_wr_hs && (r_cnt == 9'd255))
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_cnt       <= 9'd0;
            r_fetch_cnt <= 9'd0;
            r_buff_addr <= 8'd0;
            r_buff_dout <= 16'd0;
            r_buff_wr   <= 1'b0;
            r_cmd_lba   <= 32'd0;
            r_cmd_write <= 1'b0;
            r_fifo[0]   <= 16'd0;
            r_fifo[1]   <= 16'd0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_inflight  <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_buff_wr <= 1'b0;
            if (w_accept) begin
                r_cmd_lba   <= sd_lba;
                r_cmd_write <= ~sd_rd;
            end

            if (r_state == IDLE)
                r_cnt <= 9'd0;
            else if (w_rd_hs || w_wr_hs)
                r_cnt <= r_cnt + 9'd1;

            if (w_rd_hs) begin
                r_buff_wr   <= 1'b1;
                r_buff_addr <= r_cnt[7:0];
                r_buff_dout <= host_rdata;
            end else if (r_state != RD_XFER) begin
                r_buff_addr <= 8'd0;
            end

            if (r_state == WR_XFER) begin
                r_inflight <= w_fetch;
                if (w_fetch)
                    r_fetch_cnt <= r_fetch_cnt + 9'd1;
                if (r_inflight) begin
                    r_fifo[r_wptr] <= sd_buff_din;
                    r_wptr         <= ~r_wptr;
                end
                if (w_wr_hs)
                    r_rptr <= ~r_rptr;
                r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_wr_hs};
            end else begin
                r_inflight  <= 1'b0;
                r_fetch_cnt <= 9'd0;
                r_wptr      <= 1'b0;
                r_rptr      <= 1'b0;
                r_occ       <= 2'd0;
            end
        end
    end

    assign sd_ack           = (r_state == RD_XFER) || (r_state == RD_LAST) || (r_state == WR_XFER);
    assign sd_buff_addr     = (r_state == WR_XFER) ? r_fetch_cnt[7:0] : r_buff_addr;
    assign sd_buff_dout     = r_buff_dout;
    assign sd_buff_wr       = r_buff_wr;
    assign host_cmd_valid   = w_cmd_valid;
    assign host_cmd_write   = r_cmd_write;
    assign host_cmd_lba     = r_cmd_lba;
    assign host_rdata_ready = w_rdata_ready;
    assign host_wdata       = r_fifo[r_rptr];
    assign host_wdata_valid = w_wdata_valid;
    assign busy             = (r_state != IDLE);
endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: RAM and host models, sector-level reference expectations.
// Define SD_RESP_TIMEOUT_EN to also exercise the watchdog with a 50-cycle limit.
`timescale 1ns/1ps
module tb_sd_sector_responder;
`ifdef SD_RESP_TIMEOUT_EN
    localparam logic [23:0] TO = 24'd50;
`else
    localparam logic [23:0] TO = 24'd2000000;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic        host_cmd_valid, host_cmd_ready, host_cmd_write;
    logic [31:0] host_cmd_lba;
    logic [15:0] host_rdata, host_wdata;
    logic        host_rdata_valid, host_rdata_ready;
    logic        host_wdata_valid, host_wdata_ready;
    logic        busy, err;

    sd_sector_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
        .host_cmd_write(host_cmd_write), .host_cmd_lba(host_cmd_lba),
        .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
        .host_rdata_ready(host_rdata_ready), .host_wdata(host_wdata),
        .host_wdata_valid(host_wdata_valid), .host_wdata_ready(host_wdata_ready),
        .busy(busy), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] mem     [256];
    logic [15:0] ref_buf [256];
    logic [15:0] rd_words[256];
    logic        ld_all = 1'b0;
    int          rd_idx = 0;
    int          cmd_rdy_mode = 1;
    int          rd_vmode = 0;
    int          wr_rmode = 1;
    logic        wr_tog = 1'b0;

    int          cmd_cyc_q[$];
    logic [31:0] cmd_lba_q[$];
    logic        cmd_wr_q[$];
    int          bw_cyc_q[$];
    logic [7:0]  bw_addr_q[$];
    logic [15:0] bw_data_q[$];
    logic        bw_ack_q[$];
    int          wd_cyc_q[$];
    logic [15:0] wd_q[$];
    int          ack_rise_q[$], ack_fall_q[$], req_rise_q[$], cv_rise_q[$], err_rise_q[$];
    int          busy_gap_q[$];
    int          busy_low_run = 0;
    int          wv_first = -1;
    logic        prev_ack = 1'b0, prev_req = 1'b0, prev_cv = 1'b0, prev_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Buffer RAM: registered read, one cycle of latency.
    initial begin
        forever begin
            @(posedge clk_sys);
            if (ld_all)
                for (int k = 0; k < 256; k++) mem[k] <= ref_buf[k];
            else if (sd_buff_wr)
                mem[sd_buff_addr] <= sd_buff_dout;
            sd_buff_din <= mem[sd_buff_addr];
        end
    end

    // Host side: command acceptor, read-stream source, write-stream sink.
    initial begin
        logic rhs;
        host_cmd_ready = 1'b0; host_rdata = 16'd0; host_rdata_valid = 1'b0; host_wdata_ready = 1'b0;
        forever begin
            @(negedge clk_sys);
            rhs = host_rdata_valid && host_rdata_ready;
            @(posedge clk_sys); #1;
            if (rhs) rd_idx++;
            case (cmd_rdy_mode)
                0:       host_cmd_ready = 1'b0;
                1:       host_cmd_ready = 1'b1;
                default: host_cmd_ready = 1'($urandom_range(0, 1));
            endcase
            if (rd_idx < 256) begin
                host_rdata_valid = (rd_vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                host_rdata       = rd_words[rd_idx];
            end else begin
                host_rdata_valid = 1'b0;
            end
            wr_tog = ~wr_tog;
            case (wr_rmode)
                0:       host_wdata_ready = wr_tog;
                1:       host_wdata_ready = 1'b1;
                default: host_wdata_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Observation of DUT activity, mid-cycle.
    initial begin
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (host_cmd_valid && host_cmd_ready) begin
                cmd_cyc_q.push_back(cyc); cmd_lba_q.push_back(host_cmd_lba); cmd_wr_q.push_back(host_cmd_write);
            end
            if (sd_buff_wr) begin
                bw_cyc_q.push_back(cyc); bw_addr_q.push_back(sd_buff_addr);
                bw_data_q.push_back(sd_buff_dout); bw_ack_q.push_back(sd_ack);
            end
            if (host_wdata_valid && host_wdata_ready) begin
                wd_cyc_q.push_back(cyc); wd_q.push_back(host_wdata);
            end
            if (host_wdata_valid && wv_first < 0) wv_first = cyc;
            if (sd_ack && !prev_ack) ack_rise_q.push_back(cyc);
            if (!sd_ack && prev_ack) ack_fall_q.push_back(cyc);
            if ((sd_rd || sd_wr) && !prev_req) req_rise_q.push_back(cyc);
            if (host_cmd_valid && !prev_cv) cv_rise_q.push_back(cyc);
            if (err && !prev_err) err_rise_q.push_back(cyc);
            if (!busy) busy_low_run++;
            else if (busy_low_run > 0) begin busy_gap_q.push_back(busy_low_run); busy_low_run = 0; end
            prev_ack = sd_ack; prev_req = sd_rd || sd_wr; prev_cv = host_cmd_valid; prev_err = err;
        end
    end

    task automatic clear_obs();
        cmd_cyc_q.delete(); cmd_lba_q.delete(); cmd_wr_q.delete();
        bw_cyc_q.delete(); bw_addr_q.delete(); bw_data_q.delete(); bw_ack_q.delete();
        wd_cyc_q.delete(); wd_q.delete();
        ack_rise_q.delete(); ack_fall_q.delete(); req_rise_q.delete(); cv_rise_q.delete(); err_rise_q.delete();
        wv_first = -1;
    endtask

    // One complete sector as the save/load sequencer would run it, then checked against the sector model.
    task automatic do_sector(input bit rd, input bit wr, input logic [31:0] lba, input int stall,
                             input int vmode, input int rmode, input bit seqpat);
        bit ok;
        int nbad;
        @(posedge clk_sys); #2;
        clear_obs();
        rd_idx = 0; rd_vmode = vmode; wr_rmode = rmode;
        for (int k = 0; k < 256; k++) rd_words[k] = seqpat ? 16'(k) : 16'($urandom);
        cmd_rdy_mode = (stall > 0) ? 0 : 1;
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        if (stall > 0) begin
            repeat (stall) @(posedge clk_sys);
            #2;
            check("stall_busy", busy, 1);
            check("stall_no_ack", sd_ack, 0);
            check("stall_err", err, 0);
            cmd_rdy_mode = 1;
        end
        ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin @(negedge clk_sys); if (sd_ack) ok = 1; end
        check("ack_rise_seen", ok, 1);
        @(posedge clk_sys); #2;
        sd_rd = 1'b0; sd_wr = 1'b0;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin @(negedge clk_sys); if (!sd_ack) ok = 1; end
        #1;
        check("ack_fall_seen", ok, 1);
        check("done_addr_zero", sd_buff_addr, 0);
        check("cmd_count", cmd_cyc_q.size(), 1);
        if (cmd_cyc_q.size() == 1) begin
            check("cmd_lba", cmd_lba_q[0], lba);
            check("cmd_write", cmd_wr_q[0], !rd);
            if (ack_rise_q.size() > 0) check("ack_rise_latency", ack_rise_q[0] - cmd_cyc_q[0], 1);
        end
        if (req_rise_q.size() > 0 && cv_rise_q.size() > 0)
            check("cmd_valid_latency", cv_rise_q[0] - req_rise_q[0], 1);
        if (rd) begin
            check("strobe_count", bw_cyc_q.size(), 256);
            nbad = 0;
            for (int k = 0; k < bw_cyc_q.size(); k++)
                if (bw_addr_q[k] !== 8'(k) || bw_data_q[k] !== rd_words[k] || bw_ack_q[k] !== 1'b1) nbad++;
            check("rd_strobe_mismatches", nbad, 0);
            nbad = 0;
            for (int k = 0; k < 256; k++) begin
                ref_buf[k] = rd_words[k];
                if (mem[k] !== ref_buf[k]) nbad++;
            end
            check("buffer_contents", nbad, 0);
            if (bw_cyc_q.size() > 0 && ack_fall_q.size() > 0)
                check("ack_fall_after_last_strobe", ack_fall_q[0] - bw_cyc_q[bw_cyc_q.size()-1], 1);
            if (vmode == 0 && bw_cyc_q.size() == 256 && ack_rise_q.size() > 0) begin
                check("rd_first_strobe", bw_cyc_q[0] - ack_rise_q[0], 1);
                check("rd_one_per_cycle", bw_cyc_q[255] - bw_cyc_q[0], 255);
            end
        end else begin
            check("wr_handshakes", wd_q.size(), 256);
            nbad = 0;
            for (int k = 0; k < wd_q.size(); k++) if (wd_q[k] !== ref_buf[k]) nbad++;
            check("wr_data_mismatches", nbad, 0);
            check("wr_no_buffer_writes", bw_cyc_q.size(), 0);
            if (ack_rise_q.size() > 0) check("wr_first_valid", wv_first - ack_rise_q[0], 2);
            if (wd_cyc_q.size() > 0 && ack_fall_q.size() > 0)
                check("ack_fall_after_last_hs", ack_fall_q[0] - wd_cyc_q[wd_cyc_q.size()-1], 1);
            if (rmode == 1 && wd_cyc_q.size() == 256)
                check("wr_one_per_cycle", wd_cyc_q[255] - wd_cyc_q[0], 255);
        end
        check("err_clear", err, 0);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; sd_lba = 32'd0; sd_rd = 1'b0; sd_wr = 1'b0;
        for (int k = 0; k < 256; k++) begin ref_buf[k] = 16'd0; rd_words[k] = 16'd0; end
        #1;
        check("reset_outputs", |{sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, host_cmd_valid, host_cmd_write,
                                 host_rdata_ready, host_wdata, host_wdata_valid, busy, err}, 0);
        check("reset_lba", host_cmd_lba, 0);
        ld_all = 1'b1;
        repeat (3) @(posedge clk_sys);
        #3; reset = 1'b0; ld_all = 1'b0;

        // Read lba 5 with a sequential stream, no stalls.
        do_sector(1, 0, 32'd5, 0, 0, 1, 1);

        // Write lba 3 from a preloaded buffer, host ready toggling.
        for (int k = 0; k < 256; k++) ref_buf[k] = 16'hA500 + 16'(k);
        @(posedge clk_sys); #2; ld_all = 1'b1;
        @(posedge clk_sys); #2; ld_all = 1'b0;
        do_sector(0, 1, 32'd3, 0, 0, 0, 0);

        // Both requests high: read wins.
        do_sector(1, 1, $urandom, 0, 0, 1, 0);

        // Stalled command acceptance and a randomly throttled read stream.
        do_sector(1, 0, $urandom, 20, 1, 1, 0);

        // Write back what that read left in the buffer, random host ready.
        do_sector(0, 1, $urandom, 0, 0, 2, 0);

        // Four-sector load: re-request on every ack fall.
        busy_gap_q.delete();
        for (int i = 0; i < 4; i++) do_sector(1, 0, 32'(i), 0, 0, 1, 0);
        check("busy_gap_count", busy_gap_q.size(), 4);
        if (busy_gap_q.size() == 4) begin
            check("busy_gap_1", busy_gap_q[1], 1);
            check("busy_gap_2", busy_gap_q[2], 1);
            check("busy_gap_3", busy_gap_q[3], 1);
        end

        // Reset in the middle of a read.
        @(posedge clk_sys); #2;
        clear_obs();
        rd_idx = 0; rd_vmode = 0; cmd_rdy_mode = 1;
        for (int k = 0; k < 256; k++) rd_words[k] = 16'($urandom);
        sd_lba = 32'h1234_5678; sd_rd = 1'b1;
        ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin @(negedge clk_sys); if (sd_ack) ok = 1; end
        check("mid_rst_ack_rise", ok, 1);
        @(posedge clk_sys); #2; sd_rd = 1'b0;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin @(negedge clk_sys); if (bw_cyc_q.size() >= 100) ok = 1; end
        check("mid_rst_word100", ok, 1);
        @(posedge clk_sys); #3;
        reset = 1'b1; rd_idx = 0;
        #1;
        check("mid_rst_outputs", |{sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, host_cmd_valid, host_cmd_write,
                                   host_rdata_ready, host_wdata, host_wdata_valid, busy, err}, 0);
        check("mid_rst_lba", host_cmd_lba, 0);
        repeat (3) @(posedge clk_sys);
        #3; reset = 1'b0;
        do_sector(1, 0, 32'h77, 0, 0, 1, 0);

`ifdef SD_RESP_TIMEOUT_EN
        // Command never accepted: watchdog aborts, err stays until the next accept.
        @(posedge clk_sys); #2;
        clear_obs();
        cmd_rdy_mode = 0; sd_lba = 32'd9; sd_rd = 1'b1;
        repeat (3) @(posedge clk_sys);
        #2; sd_rd = 1'b0;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin @(negedge clk_sys); if (err) ok = 1; end
        #1;
        check("to_err_set", ok, 1);
        if (err_rise_q.size() > 0 && cv_rise_q.size() > 0)
            check("to_latency", err_rise_q[0] - cv_rise_q[0], 50);
        repeat (4) @(negedge clk_sys);
        #1;
        check("to_busy_low", busy, 0);
        check("to_err_sticky", err, 1);
        check("to_no_ack", ack_rise_q.size(), 0);
        check("to_no_cmd_hs", cmd_cyc_q.size(), 0);
        cmd_rdy_mode = 1;
        do_sector(1, 0, 32'd10, 0, 0, 1, 0);
`else
        // Without the watchdog a long stall is simply waited out.
        do_sector(1, 0, 32'd11, 60, 0, 1, 0);
`endif

        // Final write with the host always ready.
        do_sector(0, 1, $urandom, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit: observed expired expected finished");
        $fatal(1, "time limit");
    end
endmodule
